// File: rtl/exp_range_reduce_param.sv
// Range-reduced e^x / 2^x front end: splits x into k*ln2 + r, hands r to an
// external e^r core, then rescales the core's answer by 2^k with saturation.
module exp_range_reduce_param #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 40,
  parameter logic signed [WIDTH-1:0] LN2_Q     = 64'h000000B17217F7D1,
  parameter logic signed [WIDTH-1:0] INV_LN2_Q = 64'h00000171547652B8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    x_in_valid,
  output logic                    x_in_ready,
  input  logic                    pow2_mode,
  output logic signed [WIDTH-1:0] exp_out,
  output logic                    exp_ovf,
  output logic                    exp_unf,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] core_req_data,
  output logic                    core_req_valid,
  input  logic                    core_req_ready,
  input  logic signed [WIDTH-1:0] core_rsp_data,
  input  logic                    core_rsp_valid,
  output logic                    core_rsp_ready
);
  typedef enum logic [2:0] {IDLE, CALC_K, CALC_R, CORE_REQ, CORE_WAIT, SCALE, DONE} state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] data;
    logic                    ovf;
    logic                    unf;
  } res_t;

  localparam logic signed [2*WIDTH-1:0] RND_K = (2*WIDTH)'(1) <<< (2*FRAC-1);
  localparam logic signed [WIDTH:0]     RND_P = (WIDTH+1)'(1) <<< (FRAC-1);
  localparam logic signed [WIDTH-1:0]   KMAX  = WIDTH'(WIDTH-1);
  localparam logic signed [WIDTH-1:0]   KW    = WIDTH'(WIDTH);
  localparam logic signed [WIDTH-1:0]   SAT   = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                  state;
  logic signed [WIDTH-1:0] x_q, k_q, r_q, m_q;
  logic                    p2_q;
  logic signed [WIDTH-1:0] k_nxt, r_nxt, d_p, neg_k;
  res_t                    res;

  assign core_req_data = r_q;

  always_comb begin
    k_nxt = '0;
    r_nxt = '0;
    d_p   = x_q - (k_q <<< FRAC);
    neg_k = -k_q;
    if (p2_q) begin
      k_nxt = WIDTH'(((WIDTH+1)'(x_q) + RND_P) >>> FRAC);
      r_nxt = WIDTH'(((2*WIDTH)'(d_p) * (2*WIDTH)'(LN2_Q)) >>> FRAC);
    end else begin
      k_nxt = WIDTH'(((2*WIDTH)'(x_q) * (2*WIDTH)'(INV_LN2_Q) + RND_K) >>> (2*FRAC));
      r_nxt = x_q - k_q * LN2_Q;
    end
  end

  // m is positive, so any set bit that would land on or above the sign bit saturates
  always_comb begin
    res = '0;
    if (!k_q[WIDTH-1]) begin
      if (k_q >= KMAX || (m_q >> (KMAX - k_q)) != '0) begin
        res.data = SAT;
        res.ovf  = 1'b1;
      end else begin
        res.data = m_q << k_q;
      end
    end else if (neg_k >= KW) begin
      res.unf = 1'b1;
    end else begin
      res.data = m_q >>> neg_k;
      res.unf  = (res.data == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      x_in_ready     <= 1'b1;
      output_valid   <= 1'b0;
      exp_out        <= '0;
      exp_ovf        <= 1'b0;
      exp_unf        <= 1'b0;
      core_req_valid <= 1'b0;
      core_rsp_ready <= 1'b0;
      x_q            <= '0;
      p2_q           <= 1'b0;
      k_q            <= '0;
      r_q            <= '0;
      m_q            <= '0;
    end else begin
      unique case (state)
        IDLE: if (x_in_valid && x_in_ready) begin
          x_q        <= x_in;
          p2_q       <= pow2_mode;
          x_in_ready <= 1'b0;
          state      <= CALC_K;
        end
        CALC_K: begin
          k_q   <= k_nxt;
          state <= CALC_R;
        end
        CALC_R: begin
          r_q            <= r_nxt;
          core_req_valid <= 1'b1;
          state          <= CORE_REQ;
        end
        CORE_REQ: if (core_req_ready) begin
          core_req_valid <= 1'b0;
          core_rsp_ready <= 1'b1;
          state          <= CORE_WAIT;
        end
        CORE_WAIT: if (core_rsp_valid) begin
          m_q            <= core_rsp_data;
          core_rsp_ready <= 1'b0;
          state          <= SCALE;
        end
        SCALE: begin
          exp_out      <= res.data;
          exp_ovf      <= res.ovf;
          exp_unf      <= res.unf;
          output_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: if (output_ready) begin
          output_valid <= 1'b0;
          x_in_ready   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/exp_range_reduce_param.md
EXP_RANGE_REDUCE_PARAM -- requirements
Module: exp_range_reduce_param

Interface
REQ-001 Parameter WIDTH, default 64; total signed fixed-point width of x_in, exp_out and core data.
REQ-002 Parameter FRAC, default 40; fractional bits (default format S1.23.40).
REQ-003 Parameter LN2_Q, default 64'h000000B17217F7D1; ln(2) in Q(FRAC).
REQ-004 Parameter INV_LN2_Q, default 64'h00000171547652B8; 1/ln(2) in Q(FRAC).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 x_in  in  WIDTH  signed operand.
REQ-008 x_in_valid  in  1  operand valid.
REQ-009 x_in_ready  out  1  block can accept operand.
REQ-010 pow2_mode  in  1  0: e^x; 1: 2^x; sampled with x_in.
REQ-011 exp_out  out  WIDTH  signed result.
REQ-012 exp_ovf  out  1  result saturated high; valid with output_valid.
REQ-013 exp_unf  out  1  result flushed or shifted to zero; valid with output_valid.
REQ-014 output_valid  in/out: out  1  result valid.
REQ-015 output_ready  in  1  consumer accepts result.
REQ-016 core_req_data  out  WIDTH  reduced argument r to external e^r core, |r| <= ln2/2.
REQ-017 core_req_valid / core_req_ready  out / in  1  core request handshake.
REQ-018 core_rsp_data  in  WIDTH  e^r from core, Q(FRAC), positive.
REQ-019 core_rsp_valid / core_rsp_ready  in / out  1  core response handshake.

Function
REQ-020 States SHALL be IDLE, CALC_K, CALC_R, CORE_REQ, CORE_WAIT, SCALE, DONE; one operation in flight.
REQ-021 IDLE: x_in_ready=1; on x_in_valid&x_in_ready latch x_in and pow2_mode, x_in_ready<=0, go CALC_K.
REQ-022 CALC_K, exp mode: k = (x*INV_LN2_Q + 2^(2*FRAC-1)) >>> 2*FRAC, 2*WIDTH signed product, round-half-up; pow2 mode: k = (x + 2^(FRAC-1)) >>> FRAC.
REQ-023 CALC_R, exp mode: r = x - low WIDTH bits of (k*LN2_Q); pow2 mode: r = ((x - (k<<FRAC)) * LN2_Q) >>> FRAC.
REQ-024 CORE_REQ: core_req_valid=1, core_req_data=r held stable; on core_req_ready go CORE_WAIT.
REQ-025 CORE_WAIT: core_req_valid=0, core_rsp_ready=1; on core_rsp_valid latch core_rsp_data as m, go SCALE; core_rsp_ready=0 in all other states.
REQ-026 SCALE, k>=0: if k>=WIDTH-1 or any bit of m above position WIDTH-2-k is set, exp_out=2^(WIDTH-1)-1, exp_ovf=1; else exp_out=m<<k.
REQ-027 SCALE, k<0: if -k>=WIDTH, exp_out=0, exp_unf=1; else exp_out=m>>>(-k), exp_unf=1 iff result is 0.
REQ-028 DONE: output_valid=1; exp_out/exp_ovf/exp_unf stable until output_ready; on output_ready go IDLE, output_valid<=0.
REQ-029 Latency with core ready and single-cycle response: accept at cycle 0, core_req_valid at cycle 3, output_valid at cycle 6; throughput one result per 7 cycles minimum.
REQ-030 Core stalls (req_ready or rsp_valid low) SHALL extend latency cycle-for-cycle, no data loss.
REQ-031 x_in_valid SHALL be ignored outside IDLE; simultaneous output_ready and new x_in_valid in DONE take effect on the next IDLE cycle only.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, x_in_ready=1, output_valid=0, exp_out=0, exp_ovf=0, exp_unf=0, core_req_valid=0, core_rsp_ready=0, core_req_data=0, k and r registers to 0.
REQ-033 Reset mid-operation SHALL discard the in-flight operand; no stale result after deassert.

Verification
REQ-034 x_in=0, exp mode, ideal core model -> core_req_data=0, exp_out=0x0000010000000000, flags 0, output_valid at cycle 6.
REQ-035 x_in=0x0000010000000000 (1.0), exp mode -> k=1, core_req_data~0.306853, exp_out within 2^-30 of 2.718282, flags 0.
REQ-036 x_in=30.0 exp mode -> k=43, exp_out=0x7FFFFFFFFFFFFFFF, exp_ovf=1; x_in=-50.0 -> k=-72, exp_out=0, exp_unf=1.
REQ-037 pow2_mode=1, x_in=3.0 -> core_req_data=0, exp_out=0x0000080000000000 (8.0), flags 0.
REQ-038 output_ready low 5 cycles in DONE, core_req_ready low 3 cycles -> outputs stable, x_in_ready=0 throughout, latency +3.
REQ-039 rst_n pulsed low during CORE_WAIT -> all outputs at reset values immediately, next operand 1.0 yields correct 2.718282.
